// File: rtl/lemming_fall_monitor_pkg.sv
// Shared types for the lemming fall monitor: event codes, monitor states, walker status encoding.
package lemming_mon_pkg;

   localparam int unsigned EVT_CODE_W = 3;
   localparam int unsigned DROP_W     = 8;

   // Event codes carried on evt_code
   typedef enum logic [2:0] {
      TURN       = 3'd0,
      FALL_START = 3'd1,
      LAND       = 3'd2,
      SPLAT      = 3'd3,
      DIG_START  = 3'd4,
      ILLEGAL    = 3'd7
   } evt_e;

   typedef enum logic [1:0] {
      GROUND  = 2'd0,
      FALLING = 2'd1,
      DEAD    = 2'd2
   } mon_state_e;

   // One-hot walker status, bit order {walk_left, walk_right, aaah, digging}
   typedef enum logic [3:0] {
      WALK_L = 4'b1000,
      WALK_R = 4'b0100,
      FALL   = 4'b0010,
      DIG    = 4'b0001
   } status_e;

   // True when exactly one status bit is set
   function automatic logic is_one_hot(input logic [3:0] s);
      return (s != 4'b0000) && ((s & (s - 4'd1)) == 4'b0000);
   endfunction

endpackage

// File: rtl/lemming_evt_fifo.sv
// Small synchronous FIFO for monitor events; a push into a full FIFO lands only if a pop frees a slot.
module lemming_evt_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 11
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push_i,
   input  logic [W-1:0] wdata_i,
   input  logic         pop_i,
   output logic [W-1:0] rdata_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [W-1:0] mem_q [DEPTH];
   logic [AW:0]  wr_q;
   logic [AW:0]  rd_q;
   logic         do_pop;
   logic         do_push;

   // Pointer-based occupancy: extra MSB distinguishes full from empty
   always_comb begin
      empty_o = (wr_q == rd_q);
      full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
      do_pop  = pop_i && !empty_o;
      do_push = push_i && (!full_o || do_pop);
      rdata_o = mem_q[rd_q[AW-1:0]];
   end

   // Pointer update
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + (AW+1)'(1);
         if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
      end
   end

   // Storage write; contents need no reset since empty gates the read side
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/lemming_fall_monitor.sv
// Observes the walker's one-hot status, times falls, declares splats and queues trace events.
module lemming_fall_monitor
   import lemming_mon_pkg::*;
#(
   parameter int unsigned SPLAT_CYCLES = 20,
   parameter int unsigned CNT_W        = 8,
   parameter int unsigned EVT_DEPTH    = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             walk_left,
   input  logic             walk_right,
   input  logic             aaah,
   input  logic             digging,
   output logic             alive,
   output logic             splat,
   output logic [CNT_W-1:0] fall_len,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [2:0]       evt_code,
   output logic [CNT_W-1:0] evt_data,
   output logic [7:0]       evt_drop_cnt
);

   localparam int unsigned      EVT_W     = EVT_CODE_W + CNT_W;
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] SPLAT_LIM = CNT_W'(SPLAT_CYCLES);

   mon_state_e        state_q;
   status_e           prev_q;
   logic              illegal_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              alive_q;
   logic              splat_q;
   logic [DROP_W-1:0] drop_q;

   logic [3:0]        status_c;
   logic              legal_c;
   logic              push_c;
   evt_e              code_c;
   logic [CNT_W-1:0]  data_c;
   logic [EVT_W-1:0]  fifo_rdata;
   logic              fifo_full;
   logic              fifo_empty;
   logic              pop_c;

   assign status_c = {walk_left, walk_right, aaah, digging};
   assign legal_c  = is_one_hot(status_c);

   // Event encoder: at most one event per cycle, illegal status first
   always_comb begin
      push_c = 1'b0;
      code_c = TURN;
      data_c = '0;
      if (state_q != DEAD) begin
         if (!legal_c) begin
            if (!illegal_q) begin
               push_c = 1'b1;
               code_c = ILLEGAL;
               data_c = CNT_W'(status_c);
            end
         end else if (state_q == GROUND) begin
            if (status_c == FALL) begin
               push_c = 1'b1;
               code_c = FALL_START;
            end else if (prev_q == WALK_L && status_c == WALK_R) begin
               push_c = 1'b1;
               code_c = TURN;
               data_c = CNT_W'(1);
            end else if (prev_q == WALK_R && status_c == WALK_L) begin
               push_c = 1'b1;
               code_c = TURN;
            end else if ((prev_q == WALK_L || prev_q == WALK_R) && status_c == DIG) begin
               push_c = 1'b1;
               code_c = DIG_START;
            end
         end else if (status_c != FALL) begin
            push_c = 1'b1;
            code_c = (cnt_q > SPLAT_LIM) ? SPLAT : LAND;
            data_c = cnt_q;
         end
      end
   end

   // Monitor FSM with fall counter; illegal status freezes state, counter and prev status
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= GROUND;
         prev_q    <= WALK_L;
         illegal_q <= 1'b0;
         cnt_q     <= '0;
         alive_q   <= 1'b1;
         splat_q   <= 1'b0;
      end else begin
         splat_q   <= 1'b0;
         illegal_q <= !legal_c;
         if (legal_c && state_q != DEAD) begin
            prev_q <= status_e'(status_c);
            case (state_q)
               GROUND: begin
                  if (status_c == FALL) begin
                     state_q <= FALLING;
                     cnt_q   <= CNT_W'(1);
                  end
               end
               FALLING: begin
                  if (status_c == FALL) begin
                     if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
                  end else if (cnt_q > SPLAT_LIM) begin
                     state_q <= DEAD;
                     alive_q <= 1'b0;
                     splat_q <= 1'b1;
                  end else begin
                     state_q <= GROUND;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign pop_c = evt_valid && evt_ready;

   // Count events lost because the FIFO was full with no pop this cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         drop_q <= '0;
      end else if (push_c && fifo_full && !pop_c && drop_q != '1) begin
         drop_q <= drop_q + DROP_W'(1);
      end
   end

   lemming_evt_fifo #(
      .DEPTH (EVT_DEPTH),
      .W     (EVT_W)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push_c),
      .wdata_i ({code_c, data_c}),
      .pop_i   (pop_c),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign alive        = alive_q;
   assign splat        = splat_q;
   assign fall_len     = cnt_q;
   assign evt_valid    = !fifo_empty;
   assign evt_code     = fifo_rdata[EVT_W-1 -: EVT_CODE_W];
   assign evt_data     = fifo_rdata[CNT_W-1:0];
   assign evt_drop_cnt = drop_q;

endmodule

// File: tb/tb_lemming_fall_monitor.sv
// Scoreboard bench for lemming_fall_monitor: expected events queued at drive time, compared on handshake.
module tb_lemming_fall_monitor;

   localparam logic [2:0] C_TURN  = 3'd0;
   localparam logic [2:0] C_FALL  = 3'd1;
   localparam logic [2:0] C_LAND  = 3'd2;
   localparam logic [2:0] C_SPLAT = 3'd3;
   localparam logic [2:0] C_DIG   = 3'd4;
   localparam logic [2:0] C_ILL   = 3'd7;

   localparam logic [3:0] S_WL  = 4'b1000;
   localparam logic [3:0] S_WR  = 4'b0100;
   localparam logic [3:0] S_AH  = 4'b0010;
   localparam logic [3:0] S_DG  = 4'b0001;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       walk_left = 1'b1;
   logic       walk_right = 1'b0;
   logic       aaah = 1'b0;
   logic       digging = 1'b0;
   logic       evt_ready = 1'b1;
   logic       alive;
   logic       splat;
   logic [7:0] fall_len;
   logic       evt_valid;
   logic [2:0] evt_code;
   logic [7:0] evt_data;
   logic [7:0] evt_drop_cnt;

   typedef struct {
      logic [2:0] code;
      logic [7:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   splat_seen = 0;

   always #5 clk = ~clk;

   lemming_fall_monitor #(
      .SPLAT_CYCLES (20),
      .CNT_W        (8),
      .EVT_DEPTH    (4)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .walk_left    (walk_left),
      .walk_right   (walk_right),
      .aaah         (aaah),
      .digging      (digging),
      .alive        (alive),
      .splat        (splat),
      .fall_len     (fall_len),
      .evt_valid    (evt_valid),
      .evt_ready    (evt_ready),
      .evt_code     (evt_code),
      .evt_data     (evt_data),
      .evt_drop_cnt (evt_drop_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic expect_evt(input logic [2:0] c, input logic [7:0] d);
      exp_t e;
      e.code = c;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic set_status(input logic [3:0] s);
      {walk_left, walk_right, aaah, digging} = s;
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || evt_valid) && n < 50) begin
         step(1);
         n++;
      end
      check({tag, "_drained"}, 32'(exp_q.size() == 0 && !evt_valid), 32'd1);
   endtask

   // Mid-cycle monitor: count splat pulses and score each accepted event
   always @(negedge clk) begin
      if (splat === 1'b1) splat_seen++;
      if (!reset && evt_valid && evt_ready) begin
         if (exp_q.size() == 0) begin
            check("evt_unexpected_code", 32'(evt_code), 32'hFFFF);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("evt_code", 32'(evt_code), 32'(e.code));
            check("evt_data", 32'(evt_data), 32'(e.data));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      set_status(S_WL);
      evt_ready = 1'b1;
      step(2);
      check("rst_alive", 32'(alive), 32'd1);
      check("rst_splat", 32'(splat), 32'd0);
      check("rst_fall_len", 32'(fall_len), 32'd0);
      check("rst_evt_valid", 32'(evt_valid), 32'd0);
      check("rst_drop", 32'(evt_drop_cnt), 32'd0);
      reset = 1'b0;

      // Idle walking left
      step(5);
      check("t1_alive", 32'(alive), 32'd1);
      check("t1_evt_valid", 32'(evt_valid), 32'd0);
      check("t1_fall_len", 32'(fall_len), 32'd0);
      check("t1_drop", 32'(evt_drop_cnt), 32'd0);

      // 20-cycle fall lands safely
      set_status(S_AH);
      expect_evt(C_FALL, 8'd0);
      step(1);
      check("t2_fall_len_first", 32'(fall_len), 32'd1);
      step(19);
      check("t2_fall_len_live", 32'(fall_len), 32'd20);
      set_status(S_WL);
      expect_evt(C_LAND, 8'd20);
      step(1);
      check("t2_fall_len_hold", 32'(fall_len), 32'd20);
      check("t2_alive", 32'(alive), 32'd1);
      drain("t2");
      check("t2_no_splat", 32'(splat_seen), 32'd0);

      // Six turns with consumer stalled: four queued, two dropped
      evt_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         set_status((i % 2 == 0) ? S_WR : S_WL);
         if (i < 4) expect_evt(C_TURN, (i % 2 == 0) ? 8'd1 : 8'd0);
         step(1);
      end
      check("t4_drop", 32'(evt_drop_cnt), 32'd2);
      check("t4_valid", 32'(evt_valid), 32'd1);
      check("t4_head_code", 32'(evt_code), 32'(C_TURN));
      check("t4_head_data", 32'(evt_data), 32'd1);
      step(2);
      check("t4_head_stable", 32'(evt_data), 32'd1);
      check("t4_drop_stable", 32'(evt_drop_cnt), 32'd2);

      // Full FIFO, pop and push on the same edge
      evt_ready = 1'b1;
      set_status(S_WR);
      expect_evt(C_TURN, 8'd1);
      step(1);
      check("t5_drop_unchanged", 32'(evt_drop_cnt), 32'd2);
      drain("t5");

      // Walk -> dig, then back to walking (no event)
      set_status(S_DG);
      expect_evt(C_DIG, 8'd0);
      step(1);
      set_status(S_WR);
      step(1);
      drain("dig");

      // Illegal run in GROUND reports once
      set_status(4'b1100);
      expect_evt(C_ILL, 8'd12);
      step(3);
      check("t6_fall_len_hold", 32'(fall_len), 32'd20);
      set_status(S_WR);
      step(1);
      drain("t6");

      // Illegal run mid-fall freezes the counter
      set_status(S_AH);
      expect_evt(C_FALL, 8'd0);
      step(3);
      set_status(4'b0011);
      expect_evt(C_ILL, 8'd3);
      step(2);
      check("ill_fall_frozen", 32'(fall_len), 32'd3);
      set_status(S_AH);
      step(2);
      check("ill_fall_resumed", 32'(fall_len), 32'd5);
      set_status(S_WR);
      expect_evt(C_LAND, 8'd5);
      step(1);
      drain("ill_fall");

      // 21-cycle fall is fatal
      set_status(S_AH);
      expect_evt(C_FALL, 8'd0);
      step(21);
      check("t3_fall_len", 32'(fall_len), 32'd21);
      set_status(S_WR);
      expect_evt(C_SPLAT, 8'd21);
      step(1);
      check("t3_splat_pulse", 32'(splat), 32'd1);
      check("t3_dead", 32'(alive), 32'd0);
      step(1);
      check("t3_splat_low", 32'(splat), 32'd0);
      set_status(S_WL);
      step(1);
      set_status(S_DG);
      step(1);
      set_status(4'b1100);
      step(1);
      set_status(S_WL);
      drain("t3");
      check("t3_splat_once", 32'(splat_seen), 32'd1);
      check("t3_still_dead", 32'(alive), 32'd0);
      check("t3_fall_len_hold", 32'(fall_len), 32'd21);

      // Reset revives the monitor
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      check("rst2_alive", 32'(alive), 32'd1);
      check("rst2_drop", 32'(evt_drop_cnt), 32'd0);

      // Reset mid-fall with a queued event
      evt_ready = 1'b0;
      set_status(S_AH);
      step(10);
      check("rstm_fall_len", 32'(fall_len), 32'd10);
      check("rstm_queued", 32'(evt_valid), 32'd1);
      reset = 1'b1;
      set_status(S_WL);
      step(1);
      check("rstm_fall_len_clr", 32'(fall_len), 32'd0);
      check("rstm_fifo_empty", 32'(evt_valid), 32'd0);
      check("rstm_alive", 32'(alive), 32'd1);
      reset = 1'b0;
      evt_ready = 1'b1;
      step(1);
      check("rstm_no_evt", 32'(evt_valid), 32'd0);
      set_status(S_AH);
      expect_evt(C_FALL, 8'd0);
      step(1);
      check("rstm_ground_fall", 32'(fall_len), 32'd1);
      set_status(S_WL);
      expect_evt(C_LAND, 8'd1);
      step(1);
      drain("rstm");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
